load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential data-memory access unit sitting between the core's execute stage and the data bus. It consumes the decoder's memory controls (load/store request, access size, sign extension), the ALU-computed address and the rs2 store value. It runs a valid/ready bus transaction with byte enables and lane replication, stalls the core until the access completes, and returns the lane-extracted, sign/zero-extended load value for register writeback.

## Interface

Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_load  in  1  load requested by the current instruction
- req_store  in  1  store requested by the current instruction
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_sign_ext  in  1  1 sign-extends load data, 0 zero-extends
- req_addr  in  32  byte address from the ALU
- req_wdata  in  32  store data (rs2)
- stall  out  1  core must hold the current instruction and its request inputs
- done  out  1  one-cycle pulse: access complete
- rdata  out  32  extended load result; valid while done=1, held until the next load completes
- misaligned  out  1  one-cycle pulse: misaligned access rejected (macro-dependent)
- mem_valid  out  1  bus request valid
- mem_ready  in  1  bus accepts the request this cycle
- mem_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
- mem_we  out  1  1 write, 0 read
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

## Operation

- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - req_store or req_load high: latch addr, size, sign_ext, we and the formatted wdata/be; go to REQ.
  - req_store has priority if both are high.
- REQ:
  - mem_valid=1; mem_addr, mem_we, mem_be and mem_wdata are stable until the handshake.
  - On mem_valid & mem_ready: a store goes to DONE, a load goes to WAIT_RESP.
  - mem_rvalid is ignored in REQ.
- WAIT_RESP: on mem_rvalid, register the extracted and extended data into rdata; go to DONE.
- DONE:
  - done=1, stall=0. Request inputs are ignored this cycle.
  - Go to IDLE.
- stall = (IDLE & (req_load|req_store) & ~misaligned_now) | REQ | WAIT_RESP. It is combinational.
- Store formatting:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{req_wdata[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{req_wdata[15:0]}}.
  - word: be = 4'b1111; wdata = req_wdata.
- Load extraction:
  - byte: mem_rdata[8*addr[1:0] +: 8].
  - half: mem_rdata[16*addr[1] +: 16].
  - word: mem_rdata as-is.
  - The extracted value is extended to 32 bits per the latched sign_ext.
- Loads drive mem_be with the same enables as a store of that size.
- mem_wdata is 0 for loads.

## Timing

- Reset values: state IDLE; mem_valid, mem_we, done, misaligned, stall 0; mem_be 4'b0000; mem_addr, mem_wdata, rdata 32'h0.
- Request seen in cycle N: mem_valid rises at N+1.
- Store, mem_ready high at N+1: done at N+2. Minimum 3 cycles, 2 of them stalled.
- Load, mem_ready at N+1 and mem_rvalid at N+2: done and rdata valid at N+3.
- Each cycle of low mem_ready or late mem_rvalid adds exactly one stall cycle.
- Reset mid-transaction: the next cycle is IDLE with mem_valid=0. A late mem_rvalid arriving in IDLE is ignored, and rdata stays 0.
- A request present in the DONE cycle is not started. It is started only if it is still present in the following IDLE cycle.

## Configuration

- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned cases are half with addr[0]=1, or word with addr[1:0]≠0.
  - Such a request is detected in IDLE. misaligned pulses for one cycle, no bus transaction occurs, stall=0, done=0, and rdata is unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - misaligned is tied to 0.
  - Low address bits not used by the size are forced to 0: half uses addr[1] only, word uses addr[1:0]=00.
  - The access proceeds normally.

## Test plan

- Store word 0xDEADBEEF to 0x100, mem_ready=1 -> mem_valid at N+1 with addr 0x100, be 1111, we=1; done at N+2; stall high for N and N+1 only.
- Store byte 0xA5 to 0x203 -> mem_be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x200.
- Load byte signed from 0x102, mem_rdata 0x11802233 -> rdata 0xFFFFFF80. Same load unsigned -> 0x00000080.
- Load half, mem_ready held low 3 cycles, then rvalid 2 cycles later -> stall lasts the whole wait; done exactly once; rdata latched.
- Word load at 0x102 -> with LSU_MISALIGN_TRAP_EN: misaligned pulse, mem_valid never high. Without: access to 0x100 with be 1111.
- rst asserted during WAIT_RESP, then mem_rvalid -> next cycle IDLE with mem_valid=0; done stays 0; rdata 0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------------------------------------------------------------------
// Data-memory access unit between the execute stage and the data bus.
// It accepts one load or store request from the core, runs a single
// valid/ready bus transaction with byte enables and lane-replicated store
// data, stalls the core until the access completes, and returns the
// lane-extracted, sign/zero-extended load value.
//
// Handshake: a bus request is transferred in the cycle where mem_valid and
// mem_ready are both high. While mem_valid is high, mem_addr, mem_we, mem_be
// and mem_wdata do not change. Read data is taken only in the cycle where
// mem_rvalid is high after a load request has been accepted. mem_rvalid
// seen in any other state is ignored.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests are rejected with a one-cycle
//               misaligned pulse and no bus transaction.
//   undefined : misaligned is tied to 0 and the unused low address bits are
//               forced to 0 (half uses addr[1], word uses addr[1:0] = 00).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_load/store    memory request from the current instruction
//   req_size          00 byte, 01 half, 10/11 word
//   req_sign_ext      sign-extend (1) or zero-extend (0) load data
//   req_addr          byte address
//   req_wdata         store data (rs2)
//   stall             core must hold the instruction and its request inputs
//   done              one-cycle access-complete pulse
//   rdata             extended load result, held until the next load
//   misaligned        one-cycle rejected-access pulse
//   mem_*             data bus request/response signals
// ---------------------------------------------------------------------------
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_sign_ext,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_REQ       = 2'd1,
      S_WAIT_RESP = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;     // word-aligned bus address
   logic [1:0]  off_q, off_d;       // byte offset actually used for the lane
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   // Request decode in IDLE
   logic        req_any;
   logic        misaligned_now;
   logic [1:0]  req_off;
   logic [3:0]  fmt_be;
   logic [31:0] fmt_wdata;

   // Load extraction
   logic [31:0] lane_shifted;
   logic [31:0] load_ext;

   assign req_any = req_load | req_store;

   always_comb begin
      misaligned_now = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_size == 2'b01)
         misaligned_now = req_addr[0];
      else if (req_size[1])
         misaligned_now = (req_addr[1:0] != 2'b00);
`endif
   end

   // Offset with the bits the access size cannot use forced to zero. With
   // trapping enabled, misaligned requests never reach the bus, so forcing
   // is harmless there too.
   always_comb begin
      req_off   = req_addr[1:0];
      fmt_be    = 4'b1111;
      fmt_wdata = req_wdata;
      case (req_size)
         2'b00: begin
            req_off   = req_addr[1:0];
            fmt_be    = 4'b0001 << req_addr[1:0];
            fmt_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_off   = {req_addr[1], 1'b0};
            fmt_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            fmt_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            req_off   = 2'b00;
            fmt_be    = 4'b1111;
            fmt_wdata = req_wdata;
         end
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend by latched size.
   assign lane_shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext = lane_shifted;
      case (size_q)
         2'b00:   load_ext = {{24{sign_q & lane_shifted[7]}},  lane_shifted[7:0]};
         2'b01:   load_ext = {{16{sign_q & lane_shifted[15]}}, lane_shifted[15:0]};
         default: load_ext = lane_shifted;
      endcase
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      off_d   = off_q;
      size_d  = size_q;
      sign_d  = sign_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_any && !misaligned_now) begin
               addr_d  = {req_addr[31:2], 2'b00};
               off_d   = req_off;
               size_d  = req_size;
               sign_d  = req_sign_ext;
               we_d    = req_store;   // store wins when both are requested
               be_d    = fmt_be;
               wdata_d = req_store ? fmt_wdata : 32'h0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ready)
               state_d = we_q ? S_DONE : S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            if (mem_rvalid) begin
               rdata_d = load_ext;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= 32'h0;
         off_q   <= 2'b00;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs
   assign mem_valid  = (state_q == S_REQ);
   assign mem_addr   = addr_q;
   assign mem_we     = we_q;
   assign mem_be     = be_q;
   assign mem_wdata  = wdata_q;
   assign done       = (state_q == S_DONE);
   assign rdata      = rdata_q;
   assign misaligned = (state_q == S_IDLE) & req_any & misaligned_now;
   assign stall      = ((state_q == S_IDLE) & req_any & ~misaligned_now)
                     | (state_q == S_REQ)
                     | (state_q == S_WAIT_RESP);

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst;
   logic        req_load, req_store, req_sign_ext;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stall, done, misaligned;
   logic [31:0] rdata;
   logic        mem_valid, mem_ready, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .req_load(req_load), .req_store(req_store), .req_size(req_size),
      .req_sign_ext(req_sign_ext), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] rdata_hold = 32'h0;   // expected value of the rdata register
   logic [31:0] exp_q[$];             // expected load results in order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: byte-oriented view of the access
   // ------------------------------------------------------------------
   function automatic int nbytes(input logic [1:0] sz);
      if (sz == 2'd0) return 1;
      if (sz == 2'd1) return 2;
      return 4;
   endfunction

   // Offset of the access inside its word, rounded down to the access size.
   function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      return ((a % 4) / n) * n;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] be = 4'b0000;
      int n = nbytes(sz);
      int o = lane_off(sz, a);
      for (int i = 0; i < n; i++) be[o + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] w = 32'h0;
      int n = nbytes(sz);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn,
                                              input logic [31:0] a, input logic [31:0] word);
      logic [31:0] v = 32'h0;
      int n = nbytes(sz);
      int o = lane_off(sz, a);
      for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(o + i) +: 8];
      if (sgn && v[8*n - 1])
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   // ------------------------------------------------------------------
   // Driver: one complete access with a scheduled bus responder.
   // Cycle 0 is the cycle the request is first presented. mem_ready rises
   // at cycle 1+rdly; for loads mem_rvalid pulses at cycle 2+rdly+vdly.
   // ------------------------------------------------------------------
   task automatic run_txn(input string name, input logic st, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rword, input int rdly, input int vdly,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata);
      int done_cyc    = -1;
      int stall_cnt   = 0;
      int first_valid = -1;
      int exp_done    = st ? 2 + rdly : 3 + rdly + vdly;
      if (!st) exp_q.push_back(e_rdata);
      req_store    = st;
      req_load     = !st;
      req_size     = sz;
      req_sign_ext = sgn;
      req_addr     = a;
      req_wdata    = st ? wd : $urandom;
      mem_ready    = 1'b0;
      mem_rvalid   = 1'b0;
      mem_rdata    = $urandom;
      for (int c = 0; c < 64 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (stall) stall_cnt++;
         if (mem_valid && first_valid < 0) begin
            first_valid = c;
            chk({name, " mem_addr"},  mem_addr, a - (a % 4));
            chk({name, " mem_be"},    {28'h0, mem_be}, {28'h0, e_be});
            chk({name, " mem_we"},    {31'h0, mem_we}, {31'h0, st});
            chk({name, " mem_wdata"}, mem_wdata, st ? e_wdata : 32'h0);
         end
         if (done) begin
            done_cyc = c;
            if (!st) rdata_hold = exp_q.pop_front();
            chk({name, " rdata"}, rdata, rdata_hold);
         end
         @(posedge clk); #1;
         mem_ready  = (c + 1 >= 1 + rdly);
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (!st && (c + 1 == 2 + rdly + vdly)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rword;
         end else if (c + 1 == 1 && rdly > 0) begin
            mem_rvalid = 1'b1;    // stray response while the request waits
         end
         if (done_cyc >= 0) begin
            req_load  = 1'b0;
            req_store = 1'b0;
         end
      end
      chk({name, " first valid cycle"}, first_valid, 1);
      chk({name, " done cycle"},        done_cyc,    exp_done);
      chk({name, " stall cycles"},      stall_cnt,   exp_done);
      @(negedge clk);
      chk({name, " idle after done"}, {29'h0, done, mem_valid, stall}, 32'h0);
      chk({name, " rdata held"},      rdata, rdata_hold);
      @(posedge clk); #1;
   endtask

   // ------------------------------------------------------------------
   // Directed vectors
   // ------------------------------------------------------------------
   typedef struct {
      string       name;
      logic        st;
      logic [1:0]  sz;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rword;
      int          rdly;
      int          vdly;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        st, sgn;
      logic [31:0] wd, rw;
      int          vbits, dbits, sbits, mv;

      rst = 1'b1; req_load = 1'b0; req_store = 1'b0; req_size = 2'b00;
      req_sign_ext = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

      vecs.push_back('{"st_word", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{"st_byte", 1'b1, 2'd0, 1'b0, 32'h203, 32'h123456A5, 32'h0, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0});
      vecs.push_back('{"ld_byte_s", 1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'h11802233, 0, 0, 4'b0100, 32'h0, 32'hFFFFFF80});
      vecs.push_back('{"ld_byte_u", 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h11802233, 0, 0, 4'b0100, 32'h0, 32'h00000080});
      vecs.push_back('{"ld_half_wait", 1'b0, 2'd1, 1'b1, 32'h106, 32'h0, 32'h80017FFF, 3, 2, 4'b1100, 32'h0, 32'hFFFF8001});
      vecs.push_back('{"st_half", 1'b1, 2'd1, 1'b0, 32'h10A, 32'hCAFE1234, 32'h0, 1, 0, 4'b1100, 32'h12341234, 32'h0});
      vecs.push_back('{"ld_word", 1'b0, 2'd2, 1'b1, 32'h200, 32'h0, 32'h89ABCDEF, 1, 1, 4'b1111, 32'h0, 32'h89ABCDEF});
      vecs.push_back('{"st_size3", 1'b1, 2'd3, 1'b0, 32'h30, 32'h01020304, 32'h0, 0, 0, 4'b1111, 32'h01020304, 32'h0});
      vecs.push_back('{"ld_half_lo_u", 1'b0, 2'd1, 1'b0, 32'h040, 32'h0, 32'h1234F00D, 0, 1, 4'b0011, 32'h0, 32'h0000F00D});
`ifndef LSU_MISALIGN_TRAP_EN
      vecs.push_back('{"ld_word_mis", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h12345678, 0, 0, 4'b1111, 32'h0, 32'h12345678});
      vecs.push_back('{"ld_half_mis", 1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'hBEEF0000, 0, 0, 4'b1100, 32'h0, 32'h0000BEEF});
`endif

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset flags", {26'h0, stall, done, misaligned, mem_valid, mem_we, 1'b0}, 32'h0);
      chk("reset mem_be", {28'h0, mem_be}, 32'h0);
      chk("reset mem_addr", mem_addr, 32'h0);
      chk("reset mem_wdata", mem_wdata, 32'h0);
      chk("reset rdata", rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i])
         run_txn(vecs[i].name, vecs[i].st, vecs[i].sz, vecs[i].sgn, vecs[i].addr,
                 vecs[i].wd, vecs[i].rword, vecs[i].rdly, vecs[i].vdly,
                 vecs[i].e_be, vecs[i].e_wdata, vecs[i].e_rdata);

      // Request held through DONE: not restarted there, restarted in the
      // IDLE cycle after it.
      vbits = 0; dbits = 0; sbits = 0;
      req_store = 1'b1; req_load = 1'b0; req_size = 2'd2;
      req_addr = 32'h80; req_wdata = 32'h600DF00D; mem_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         vbits |= int'(mem_valid) << c;
         dbits |= int'(done) << c;
         sbits |= int'(stall) << c;
         @(posedge clk); #1;
         if (c == 5) req_store = 1'b0;
      end
      chk("b2b valid cycles", vbits, 32'b0010010);
      chk("b2b done cycles",  dbits, 32'b0100100);
      chk("b2b stall cycles", sbits, 32'b0011011);
      mem_ready = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
      // Misaligned requests are rejected in IDLE without a bus access.
      for (int k = 0; k < 2; k++) begin
         req_load  = (k == 0);
         req_store = (k == 1);
         req_size  = (k == 0) ? 2'd2 : 2'd1;
         req_addr  = (k == 0) ? 32'h102 : 32'h101;
         req_wdata = 32'hFFFF_FFFF;
         @(negedge clk);
         chk("mis pulse", {29'h0, misaligned, stall, done}, 32'b100);
         @(posedge clk); #1;
         req_load = 1'b0; req_store = 1'b0;
         mv = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mv |= int'(mem_valid) | int'(misaligned) | int'(done);
            @(posedge clk); #1;
         end
         chk("mis no bus", mv, 0);
         chk("mis rdata kept", rdata, rdata_hold);
      end
`endif

      // Randomized accesses against the model
      for (int r = 0; r < 40; r++) begin
         st  = $urandom_range(0, 1);
         sz  = $urandom_range(0, 3);
         sgn = $urandom_range(0, 1);
         a   = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
         a   = a - (a % nbytes(sz));
`endif
         wd  = $urandom;
         rw  = $urandom;
         run_txn("rand", st, sz, sgn, a, wd, rw, $urandom_range(0, 2), $urandom_range(0, 2),
                 model_be(sz, a), model_wdata(sz, wd), model_load(sz, sgn, a, rw));
      end

      // Reset during WAIT_RESP followed by a late response
      req_load = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h40;
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rst seq valid in REQ", {31'h0, mem_valid}, 32'h1);
      @(posedge clk); #1;
      mem_ready = 1'b0; req_load = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("rst seq stall in WAIT", {31'h0, stall}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
      @(negedge clk);
      chk("rst seq idle", {29'h0, mem_valid, stall, done}, 32'h0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("rst seq no done", {30'h0, done, mem_valid}, 32'h0);
      chk("rst seq rdata", rdata, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
